// File: rtl/framebuffer_reader_pkg.sv
// Shared frame-buffer geometry and the pixel address mapping used by both the
// drawing datapath (writes) and the frame-buffer reader (reads).
package framebuffer_reader_pkg;

  localparam int DEF_SCREEN_WIDTH  = 320;
  localparam int DEF_SCREEN_HEIGHT = 240;
  localparam int COLOUR_W          = 9;
  localparam int ADDR_W            = 17;

  // Full-width row-major address, truncated only at the end.
  function automatic logic [ADDR_W-1:0] addr(
    input logic [31:0] x,
    input logic [31:0] y,
    input int unsigned width = DEF_SCREEN_WIDTH
  );
    logic [31:0] full;
    if (width == 32'd320) full = (y << 8) + (y << 6) + x;
    else                  full = y * width + x;
    return ADDR_W'(full);
  endfunction

endpackage

// File: rtl/framebuffer_reader_tag.sv
// fb_tag_pipe: DEPTH-stage (x, y, valid) delay line that keeps pixel coordinates
// aligned with RAM read data; flush kills every in-flight valid bit.
module fb_tag_pipe #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int DEPTH = 2
) (
  input  logic          iClk,
  input  logic          iResetn,
  input  logic          flush_i,
  input  logic          vld_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          vld_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  logic [DEPTH-1:0] vld_q;
  logic [XW-1:0]    x_q [DEPTH];
  logic [YW-1:0]    y_q [DEPTH];

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i && !flush_i;
      x_q[0]   <= x_i;
      y_q[0]   <= y_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1] && !flush_i;
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign x_o   = x_q[DEPTH-1];
  assign y_o   = y_q[DEPTH-1];

endmodule

// File: rtl/framebuffer_reader.sv
// Scans a clipped rectangle of the frame-buffer RAM row-major and replays each
// stored pixel to the VGA adapter as a plot stream, one pixel per cycle.
module framebuffer_reader
  import framebuffer_reader_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int READ_LATENCY  = 2,
  localparam int XW = $clog2(SCREEN_WIDTH) + 1,
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1
) (
  input  logic                iClk,
  input  logic                iResetn,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [XW-1:0]       iX0,
  input  logic [YW-1:0]       iY0,
  input  logic [XW-1:0]       iW,
  input  logic [YW-1:0]       iH,
  output logic [ADDR_W-1:0]   oAddress,
  output logic                oRden,
  input  logic [COLOUR_W-1:0] iData,
  output logic [XW-1:0]       oX_pixel,
  output logic [YW-1:0]       oY_pixel,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy,
  output logic                oDone
);

  typedef enum logic [2:0] {S_IDLE, S_CLIP, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [XW:0] SW_X = (XW+1)'(SCREEN_WIDTH);
  localparam logic [YW:0] SH_Y = (YW+1)'(SCREEN_HEIGHT);

  state_t        state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, w_q, w_d, xe_q, xe_d, x_q, x_d;
  logic [YW-1:0] y0_q, y0_d, h_q, h_d, ye_q, ye_d, y_q, y_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [XW:0]   xsum;
  logic [YW:0]   ysum;
  logic          issue, flush;

  logic                tag_vld;
  logic [XW-1:0]       tag_x;
  logic [YW-1:0]       tag_y;
  logic                plot_q, plot_d;
  logic [XW-1:0]       xpix_q, xpix_d;
  logic [YW-1:0]       ypix_q, ypix_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  assign issue = (state_q == S_READ);
  assign flush = iAbort && (state_q != S_IDLE);
  assign xsum  = {1'b0, x0_q} + {1'b0, w_q};
  assign ysum  = {1'b0, y0_q} + {1'b0, h_q};

  always_comb begin
    state_d = state_q;
    x0_d = x0_q;  y0_d = y0_q;  w_d = w_q;  h_d = h_q;
    xe_d = xe_q;  ye_d = ye_q;  x_d = x_q;  y_d = y_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          x0_d = iX0;  y0_d = iY0;  w_d = iW;  h_d = iH;
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        xe_d = (xsum > SW_X) ? SW_X[XW-1:0] : xsum[XW-1:0];
        ye_d = (ysum > SH_Y) ? SH_Y[YW-1:0] : ysum[YW-1:0];
        x_d  = x0_q;
        y_d  = y0_q;
        if ((w_q == '0) || (h_q == '0) || ({1'b0, x0_q} >= SW_X) || ({1'b0, y0_q} >= SH_Y))
          state_d = S_DONE;
        else
          state_d = S_READ;
      end
      S_READ: begin
        if (x_q == xe_q - 1'b1) begin
          x_d = x0_q;
          if (y_q == ye_q - 1'b1) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Hold until the last in-flight read has been plotted.
        if (cnt_q == 3'(READ_LATENCY)) state_d = S_DONE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    plot_d   = tag_vld && !flush;
    xpix_d   = xpix_q;
    ypix_d   = ypix_q;
    colour_d = colour_q;
    if (plot_d) begin
      xpix_d   = tag_x;
      ypix_d   = tag_y;
      colour_d = iData;
    end
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= S_IDLE;
      x0_q <= '0;  y0_q <= '0;  w_q <= '0;  h_q <= '0;
      xe_q <= '0;  ye_q <= '0;  x_q <= '0;  y_q <= '0;
      cnt_q    <= '0;
      plot_q   <= 1'b0;
      xpix_q   <= '0;
      ypix_q   <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;  y0_q <= y0_d;  w_q <= w_d;  h_q <= h_d;
      xe_q <= xe_d;  ye_q <= ye_d;  x_q <= x_d;  y_q <= y_d;
      cnt_q    <= cnt_d;
      plot_q   <= plot_d;
      xpix_q   <= xpix_d;
      ypix_q   <= ypix_d;
      colour_q <= colour_d;
    end
  end

  fb_tag_pipe #(
    .XW    (XW),
    .YW    (YW),
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .iClk    (iClk),
    .iResetn (iResetn),
    .flush_i (flush),
    .vld_i   (issue),
    .x_i     (x_q),
    .y_i     (y_q),
    .vld_o   (tag_vld),
    .x_o     (tag_x),
    .y_o     (tag_y)
  );

  assign oRden    = issue;
  assign oAddress = issue ? addr(32'(x_q), 32'(y_q), SCREEN_WIDTH) : '0;
  assign oBusy    = (state_q != S_IDLE);
  assign oDone    = (state_q == S_DONE);
  assign oPlot    = plot_q;
  assign oX_pixel = xpix_q;
  assign oY_pixel = ypix_q;
  assign oColour  = colour_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Randomized bench for framebuffer_reader: a RAM model feeds iData, and a
// cycle-indexed reference derived from the request geometry checks every output.
module tb_framebuffer_reader;
  import framebuffer_reader_pkg::*;

  localparam int SW = 320;
  localparam int SH = 240;
  localparam int L  = 2;
  localparam int XW = 10;
  localparam int YW = 9;

  logic          iClk, iResetn, iStart, iAbort;
  logic [XW-1:0] iX0, iW;
  logic [YW-1:0] iY0, iH;
  logic [16:0]   oAddress;
  logic          oRden, oPlot, oBusy, oDone;
  logic [8:0]    iData, oColour;
  logic [XW-1:0] oX_pixel;
  logic [YW-1:0] oY_pixel;

  framebuffer_reader #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .READ_LATENCY(L)) dut (
    .iClk(iClk), .iResetn(iResetn), .iStart(iStart), .iAbort(iAbort),
    .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH),
    .oAddress(oAddress), .oRden(oRden), .iData(iData),
    .oX_pixel(oX_pixel), .oY_pixel(oY_pixel), .oColour(oColour),
    .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // RAM with READ_LATENCY cycles of read delay; junk on non-read cycles.
  logic [8:0] mem [SW*SH];
  logic [8:0] rd_pipe [L];
  always @(posedge iClk) begin
    rd_pipe[0] <= (oRden && oAddress < 17'(SW*SH)) ? mem[oAddress] : 9'($urandom);
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign iData = rd_pipe[L-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference request: cycle m_E is CLIP; nothing is expected from m_abortc on.
  bit m_active = 0;
  int m_E, m_x0, m_y0, m_cw, m_ch, m_N;
  int m_abortc;

  int cap_addr[$];
  int cap_px[$], cap_py[$], cap_pc[$];
  int done_cnt = 0;
  int done_rel = -1;

  always @(negedge iClk) begin : cmp
    int r, donr, i, j, ea, ex, ey, ec;
    bit e_busy, e_done, e_rden, e_plot;
    if (iResetn) begin
      e_busy = 0; e_done = 0; e_rden = 0; e_plot = 0;
      ea = 0; ex = 0; ey = 0; ec = 0;
      if (m_active && cyc < m_abortc) begin
        r      = cyc - m_E;
        donr   = (m_N == 0) ? 1 : m_N + L + 2;
        e_busy = (r >= 0) && (r <= donr);
        e_done = (r == donr);
        i = r - 1;
        if (m_N > 0 && i >= 0 && i < m_N) begin
          e_rden = 1;
          ea = (m_y0 + i / m_cw) * SW + m_x0 + i % m_cw;
        end
        j = r - (L + 2);
        if (m_N > 0 && j >= 0 && j < m_N) begin
          e_plot = 1;
          ex = m_x0 + j % m_cw;
          ey = m_y0 + j / m_cw;
          ec = int'(mem[ey * SW + ex]);
        end
      end
      chk("busy", int'(oBusy), int'(e_busy));
      chk("done", int'(oDone), int'(e_done));
      chk("rden", int'(oRden), int'(e_rden));
      chk("plot", int'(oPlot), int'(e_plot));
      if (e_rden) chk("address", int'(oAddress), ea);
      if (e_plot) begin
        chk("x_pixel", int'(oX_pixel), ex);
        chk("y_pixel", int'(oY_pixel), ey);
        chk("colour", int'(oColour), ec);
      end
      if (oRden) cap_addr.push_back(int'(oAddress));
      if (oPlot) begin
        cap_px.push_back(int'(oX_pixel));
        cap_py.push_back(int'(oY_pixel));
        cap_pc.push_back(int'(oColour));
      end
      if (oDone) begin
        done_cnt++;
        done_rel = cyc - m_E + 1;
      end
    end
  end

  task automatic start_req(input int x0, input int y0, input int w, input int h);
    int xe, ye;
    @(posedge iClk); #2;
    cap_addr.delete(); cap_px.delete(); cap_py.delete(); cap_pc.delete();
    done_rel = -1;
    iX0 = XW'(x0); iY0 = YW'(y0); iW = XW'(w); iH = YW'(h);
    iStart = 1'b1;
    xe = (x0 + w > SW) ? SW : x0 + w;
    ye = (y0 + h > SH) ? SH : y0 + h;
    m_cw = (w == 0 || x0 >= SW) ? 0 : xe - x0;
    m_ch = (h == 0 || y0 >= SH) ? 0 : ye - y0;
    m_N  = m_cw * m_ch;
    m_x0 = x0; m_y0 = y0;
    m_E  = cyc + 1;
    m_abortc = 32'h3fff_ffff;
    m_active = 1;
    @(posedge iClk); #2;
    iStart = 1'b0;
    iX0 = XW'($urandom); iY0 = YW'($urandom); iW = XW'($urandom); iH = YW'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int seen;
    seen = done_cnt;
    for (int k = 0; k < limit; k++) begin
      @(negedge iClk); #1;
      if (done_cnt != seen) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout: no oDone within %0d cycles (cycle %0d)", limit, cyc);
  endtask

  task automatic run_req(input int x0, input int y0, input int w, input int h);
    start_req(x0, y0, w, h);
    wait_done(m_N + L + 20);
  endtask

  task automatic abort_now(input bit with_start);
    @(posedge iClk); #2;
    iAbort = 1'b1;
    iStart = with_start;
    m_abortc = cyc + 1;
    @(posedge iClk); #2;
    iAbort = 1'b0;
    iStart = 1'b0;
  endtask

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  int exp_region [6] = '{6410, 6411, 6412, 6730, 6731, 6732};
  int exp_clip_x [4] = '{318, 319, 318, 319};
  int exp_clip_y [4] = '{238, 238, 239, 239};

  initial begin
    int dc, np, x0, y0, w, h;
    iResetn = 1'b0; iStart = 1'b0; iAbort = 1'b0;
    iX0 = '0; iY0 = '0; iW = '0; iH = '0;
    for (int i = 0; i < L; i++) rd_pipe[i] = '0;
    for (int a = 0; a < SW*SH; a++) mem[a] = 9'(a);

    repeat (3) @(posedge iClk); #2;
    chk("reset_address", int'(oAddress), 0);
    chk("reset_rden", int'(oRden), 0);
    chk("reset_plot", int'(oPlot), 0);
    chk("reset_busy", int'(oBusy), 0);
    chk("reset_done", int'(oDone), 0);
    chk("reset_colour", int'(oColour), 0);
    iResetn = 1'b1;
    repeat (2) @(posedge iClk);

    // Full screen with RAM holding addr[8:0].
    run_req(0, 0, SW, SH);
    chk("full_plots", cap_px.size(), 76800);
    chk("full_reads", cap_addr.size(), 76800);
    chk("full_done_cycle", done_rel, 76805);
    if (cap_px.size() == 76800) begin
      chk("full_first_x", cap_px[0], 0);
      chk("full_first_y", cap_py[0], 0);
      chk("full_first_colour", cap_pc[0], 0);
      chk("full_last_x", cap_px[76799], 319);
      chk("full_last_y", cap_py[76799], 239);
      chk("full_last_colour", cap_pc[76799], 511);
      chk("full_last_addr", cap_addr[76799], 76799);
    end

    for (int a = 0; a < SW*SH; a++) mem[a] = 9'($urandom);

    run_req(10, 20, 3, 2);
    chk("region_reads", cap_addr.size(), 6);
    chk("region_plots", cap_px.size(), 6);
    if (cap_addr.size() == 6)
      for (int i = 0; i < 6; i++) chk("region_addr", cap_addr[i], exp_region[i]);

    run_req(318, 238, 5, 5);
    chk("clip_plots", cap_px.size(), 4);
    if (cap_addr.size() > 0) chk("clip_first_addr", cap_addr[0], 76478);
    if (cap_px.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("clip_x", cap_px[i], exp_clip_x[i]);
        chk("clip_y", cap_py[i], exp_clip_y[i]);
      end

    run_req(5, 5, 0, 7);
    chk("w0_done_cycle", done_rel, 2);
    chk("w0_reads", cap_addr.size(), 0);
    chk("w0_plots", cap_px.size(), 0);
    run_req(320, 10, 4, 4);
    chk("x320_done_cycle", done_rel, 2);
    chk("x320_reads", cap_addr.size(), 0);
    chk("x320_plots", cap_px.size(), 0);

    // Abort on the cycle of the third plot of an 8x8 request.
    start_req(40, 50, 8, 8);
    for (int k = 0; k < 100 && cap_px.size() < 2; k++) begin
      @(negedge iClk); #1;
    end
    dc = done_cnt;
    abort_now(1'b0);
    @(posedge iClk); #2;
    chk("abort_plots", cap_px.size(), 3);
    chk("abort_no_done", done_cnt, dc);
    run_req(40, 50, 8, 8);
    chk("after_abort_plots", cap_px.size(), 64);
    chk("after_abort_done_cycle", done_rel, 64 + L + 3);

    // Start pulsed while busy must be ignored.
    start_req(100, 100, 6, 5);
    repeat (4) @(posedge iClk); #2;
    iX0 = 10'd0; iY0 = 9'd0; iW = 10'd50; iH = 9'd50; iStart = 1'b1;
    @(posedge iClk); #2;
    iStart = 1'b0;
    wait_done(60);
    chk("busy_start_plots", cap_px.size(), 30);
    repeat (6) @(posedge iClk);

    // Abort and start in the same cycle: abort wins.
    start_req(0, 0, 10, 10);
    repeat (4) @(posedge iClk);
    abort_now(1'b1);
    repeat (6) @(posedge iClk);

    // Asynchronous reset in the middle of READ.
    start_req(60, 70, 10, 10);
    repeat (8) @(posedge iClk); #2;
    np = cap_px.size();
    chk("pre_reset_plotting", int'(np > 0), 1);
    iResetn = 1'b0;
    m_active = 0;
    #1;
    chk("rst_address", int'(oAddress), 0);
    chk("rst_rden", int'(oRden), 0);
    chk("rst_x", int'(oX_pixel), 0);
    chk("rst_y", int'(oY_pixel), 0);
    chk("rst_colour", int'(oColour), 0);
    chk("rst_plot", int'(oPlot), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oDone), 0);
    repeat (2) @(posedge iClk); #2;
    iResetn = 1'b1;
    repeat (3) @(posedge iClk);

    for (int n = 0; n < 30; n++) begin
      x0 = $urandom_range(0, 330);
      y0 = $urandom_range(0, 250);
      if ($urandom_range(0, 7) == 0) begin
        w = $urandom_range(13, 1023);
        h = $urandom_range(0, 3);
      end else begin
        w = $urandom_range(0, 12);
        h = $urandom_range(0, 12);
      end
      run_req(x0, y0, w, h);
      chk("rand_plots", cap_px.size(), m_N);
      chk("rand_reads", cap_addr.size(), m_N);
      repeat ($urandom_range(0, 3)) @(posedge iClk);
    end

    repeat (4) @(posedge iClk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Read-side counterpart to the drawing datapath. The datapath writes 9-bit pixels into the shared frame-buffer RAM at address y*SCREEN_WIDTH + x. This block scans a rectangular region of that RAM, row-major, and replays each stored pixel to the VGA adapter as a plot stream. The control FSM starts it to restore the canvas after the cursor outline or clear operations have disturbed the screen, and whenever the adapter needs a full repaint.

## Interface
Parameters:
- SCREEN_WIDTH, 320, canvas width in pixels
- SCREEN_HEIGHT, 240, canvas height in pixels
- READ_LATENCY, 2, cycles from oAddress presented to matching iData valid (range 1–4)

Derived widths: XW = $clog2(SCREEN_WIDTH)+1, YW = $clog2(SCREEN_HEIGHT)+1, AW = 17.

Ports:
- iClk  in  1  clock, rising edge
- iResetn  in  1  reset, asynchronous, active-low
- iStart  in  1  one-cycle request; sampled only in IDLE
- iAbort  in  1  synchronous cancel; return to IDLE, no oDone
- iX0  in  XW  region left column
- iY0  in  YW  region top row
- iW  in  XW  region width in pixels
- iH  in  YW  region height in pixels
- oAddress  out  AW  RAM read address
- oRden  out  1  RAM read enable
- iData  in  9  RAM read data (RRRGGGBBB)
- oX_pixel  out  XW  pixel column to VGA
- oY_pixel  out  YW  pixel row to VGA
- oColour  out  9  pixel colour to VGA
- oPlot  out  1  VGA write strobe
- oBusy  out  1  high from CLIP through DONE inclusive
- oDone  out  1  one-cycle completion pulse

## Operation
- The FSM has five states: IDLE, CLIP, READ, DRAIN, DONE.
- IDLE → CLIP when iStart = 1. In the same edge, latch iX0, iY0, iW, iH.
- CLIP lasts one cycle and computes the clipped bounds:
  - xe = min(X0+W, SCREEN_WIDTH); ye = min(Y0+H, SCREEN_HEIGHT)
  - The region is empty if W = 0, H = 0, X0 ≥ SCREEN_WIDTH, or Y0 ≥ SCREEN_HEIGHT.
  - Empty → DONE. Otherwise → READ with x = X0, y = Y0.
- READ issues one address per cycle: oRden = 1, oAddress = y*SCREEN_WIDTH + x.
  - Compute the address at full width before truncating to AW.
  - Use (y<<8)+(y<<6)+x when SCREEN_WIDTH = 320.
  - x increments each cycle. At x = xe−1, x wraps to X0 and y increments.
  - After the address for (xe−1, ye−1) is issued → DRAIN.
- Each issued address pushes a tag (x, y, valid = 1) into a READ_LATENCY-deep shift pipeline. Idle cycles push valid = 0.
- When a tag reaches the pipeline end, register oX_pixel/oY_pixel from the tag, oColour = iData, and oPlot = tag valid.
- DRAIN waits READ_LATENCY+1 cycles, then → DONE.
- DONE asserts oDone for one cycle, then → IDLE.
- iStart outside IDLE is ignored.
- iAbort in any non-IDLE state, at the next edge:
  - FSM → IDLE
  - all pipeline valid bits cleared
  - oPlot = 0, oRden = 0
  - oDone not asserted
  - iAbort wins over an iStart arriving in the same cycle.
- Reset mid-operation behaves like abort, and additionally forces every output to its reset value.

## Timing
- Reset values are all zero: oAddress, oRden, oX_pixel, oY_pixel, oColour, oPlot, oBusy, oDone. The FSM resets to IDLE.
- iStart sampled at edge 0 → CLIP during cycle 1 → first oAddress during cycle 2.
- Address issued in cycle k → oPlot/oColour for that pixel valid in cycle k+READ_LATENCY+1.
- N = clipped width × clipped height.
  - oPlot is high on N consecutive cycles, with no bubbles.
  - oDone is high in cycle 2+N+READ_LATENCY+1, the cycle after the last plot.
- Empty region: oDone in cycle 2, and no oRden or oPlot at any point.
- oRden is high exactly N cycles per request.

## Structure
- Shared package: SCREEN_WIDTH/SCREEN_HEIGHT defaults, colour width (9), address width (17), and the address function addr(x, y). The datapath and this block use the same function, so the write and read address mappings cannot diverge.
- State encoding is local to this block.
- One sub-module, fb_tag_pipe, implements the parameterized READ_LATENCY-deep (x, y, valid) shift register with a synchronous flush input.

## Test plan
- Full screen (0,0,320,240), READ_LATENCY = 2, RAM model preloaded with addr[8:0]:
  - 76800 plots; first (0,0) colour 0; last (319,239) addr 76799.
  - oDone in cycle 76805.
- Region (10,20,3,2): addresses in order 6410, 6411, 6412, 6730, 6731, 6732. Each plot's colour equals the model data at that address.
- Clip (318,238,5,5): exactly 4 plots at (318,238), (319,238), (318,239), (319,239). First address 76478.
- Degenerate requests: W = 0, and separately X0 = 320.
  - oDone in cycle 2; oRden and oPlot never high.
- iAbort after 3 plots of an 8×8 request: no further oPlot or oDone. A new iStart two cycles later completes normally.
- iStart pulsed while busy is ignored. Assert iResetn = 0 mid-READ: all outputs are 0 immediately (asynchronously), and the FSM is in IDLE.
